flash_audio_sequencer: RTL and testbench

- Sequences Avalon-MM reads from the on-board flash and turns each 32-bit word into two 16-bit audio samples, released one per sample_tick.
- Supports play/pause, forward/reverse and restart, with address wrap inside a [BASE, BASE+MAX_OFFSET] window.
- Sits between the flash controller IP (Avalon slave) and the audio output path; sample_tick comes from the sample-rate divider.

---
 rtl/flash_audio_pkg.sv | 30 +++
 rtl/flash_addr_step.sv | 35 +++
 rtl/flash_audio_sequencer.sv | 193 +++++++++++++++++++
 tb/tb_flash_audio_sequencer.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/flash_audio_pkg.sv
// Shared types and constants for the flash audio playback path.
// Provides the sequencer state encoding and 32-bit word to 16-bit sample half selection.
package flash_audio_pkg;

    localparam int FLASH_ADDR_W = 23;
    localparam int FLASH_DATA_W = 32;
    localparam int SAMPLE_W     = 16;

    typedef enum logic [1:0] {
        STOPPED   = 2'd0,
        FETCH     = 2'd1,
        WAIT_DATA = 2'd2,
        READY     = 2'd3
    } seq_state_t;

    // hi=1 picks bits 31:16, hi=0 picks bits 15:0
    function automatic logic [SAMPLE_W-1:0] select_half(
        input logic [FLASH_DATA_W-1:0] word,
        input logic                    hi
    );
        logic [SAMPLE_W-1:0] res;
        if (hi) begin
            res = word[FLASH_DATA_W-1:SAMPLE_W];
        end else begin
            res = word[SAMPLE_W-1:0];
        end
        return res;
    endfunction

endpackage

// File: rtl/flash_addr_step.sv
// Combinational next word address inside the window [base, base+max_offset].
// Forward wraps the last word to base; reverse wraps base to the last word.
module flash_addr_step
    import flash_audio_pkg::*;
(
    input  logic [FLASH_ADDR_W-1:0] i_addr,
    input  logic                    i_dir,
    input  logic [FLASH_ADDR_W-1:0] i_base,
    input  logic [FLASH_ADDR_W-1:0] i_max_offset,
    output logic [FLASH_ADDR_W-1:0] o_next_addr
);

    logic [FLASH_ADDR_W-1:0] w_last;

    assign w_last = i_base + i_max_offset;

    // step by one word in the selected direction, wrapping at the window edges
    always_comb begin
        o_next_addr = i_addr;
        if (i_dir) begin
            if (i_addr == i_base) begin
                o_next_addr = w_last;
            end else begin
                o_next_addr = i_addr - {{(FLASH_ADDR_W-1){1'b0}}, 1'b1};
            end
        end else begin
            if (i_addr == w_last) begin
                o_next_addr = i_base;
            end else begin
                o_next_addr = i_addr + {{(FLASH_ADDR_W-1){1'b0}}, 1'b1};
            end
        end
    end

endmodule

// File: rtl/flash_audio_sequencer.sv
// Fetches 32-bit words from flash over Avalon-MM and releases them as two
// 16-bit samples, one per sample_tick, with play/pause, reverse and restart.
module flash_audio_sequencer
    import flash_audio_pkg::*;
#(
    parameter logic [FLASH_ADDR_W-1:0] BASE       = 23'h0,
    parameter logic [FLASH_ADDR_W-1:0] MAX_OFFSET = 23'h7FFFF,
    parameter int                      UNDERRUN_W = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    play,
    input  logic                    reverse,
    input  logic                    restart,
    input  logic                    sample_tick,
    output logic                    flash_mem_read,
    output logic [FLASH_ADDR_W-1:0] flash_mem_address,
    output logic [3:0]              flash_mem_byteenable,
    input  logic                    flash_mem_waitrequest,
    input  logic [FLASH_DATA_W-1:0] flash_mem_readdata,
    input  logic                    flash_mem_readdatavalid,
    output logic [SAMPLE_W-1:0]     audio_sample,
    output logic                    sample_valid,
    output logic [UNDERRUN_W-1:0]   underrun_count
);

    localparam logic [FLASH_ADDR_W-1:0] LAST_ADDR = BASE + MAX_OFFSET;
    localparam logic [UNDERRUN_W-1:0]   UNDERRUN_MAX = {UNDERRUN_W{1'b1}};
    localparam logic [UNDERRUN_W-1:0]   UNDERRUN_ONE = {{(UNDERRUN_W-1){1'b0}}, 1'b1};

    seq_state_t              r_state;
    logic [FLASH_ADDR_W-1:0] r_addr;
    logic [FLASH_DATA_W-1:0] r_word;
    logic                    r_half;
    logic                    r_dir_q;
    logic                    r_restart_pending;
    logic                    r_read;
    logic [SAMPLE_W-1:0]     r_sample;
    logic                    r_valid;
    logic [UNDERRUN_W-1:0]   r_underrun;

    seq_state_t              w_state_nxt;
    logic [FLASH_ADDR_W-1:0] w_addr_nxt;
    logic [FLASH_DATA_W-1:0] w_word_nxt;
    logic                    w_half_nxt;
    logic                    w_dir_nxt;
    logic                    w_pending_nxt;
    logic [SAMPLE_W-1:0]     w_sample_nxt;
    logic                    w_valid_nxt;
    logic [UNDERRUN_W-1:0]   w_underrun_nxt;

    logic [FLASH_ADDR_W-1:0] w_step_addr;
    logic [FLASH_ADDR_W-1:0] w_restart_addr;
    logic                    w_tick_run;
    logic [UNDERRUN_W-1:0]   w_underrun_inc;
    seq_state_t              w_restart_state;

    flash_addr_step u_addr_step (
        .i_addr       (r_addr),
        .i_dir        (r_dir_q),
        .i_base       (BASE),
        .i_max_offset (MAX_OFFSET),
        .o_next_addr  (w_step_addr)
    );

    assign w_restart_addr  = reverse ? LAST_ADDR : BASE;
    assign w_restart_state = play ? FETCH : STOPPED;
    assign w_tick_run      = sample_tick & play;
    assign w_underrun_inc  = (r_underrun == UNDERRUN_MAX) ? r_underrun : (r_underrun + UNDERRUN_ONE);

    // next-state and datapath decisions for the fetch/playback sequencer
    always_comb begin
        w_state_nxt    = r_state;
        w_addr_nxt     = r_addr;
        w_word_nxt     = r_word;
        w_half_nxt     = r_half;
        w_dir_nxt      = r_dir_q;
        w_pending_nxt  = r_restart_pending;
        w_sample_nxt   = r_sample;
        w_valid_nxt    = 1'b0;
        w_underrun_nxt = r_underrun;

        case (r_state)
            STOPPED: begin
                if (restart) begin
                    w_addr_nxt  = w_restart_addr;
                    w_state_nxt = w_restart_state;
                end else if (play) begin
                    w_state_nxt = FETCH;
                end else begin
                    w_state_nxt = STOPPED;
                end
            end
            FETCH: begin
                // address must stay put while the request is outstanding
                if (restart) begin
                    w_pending_nxt = 1'b1;
                end else begin
                    w_pending_nxt = r_restart_pending;
                end
                if (!flash_mem_waitrequest) begin
                    w_state_nxt = WAIT_DATA;
                end else begin
                    w_state_nxt = FETCH;
                end
                if (w_tick_run) begin
                    w_underrun_nxt = w_underrun_inc;
                end else begin
                    w_underrun_nxt = r_underrun;
                end
            end
            WAIT_DATA: begin
                if (flash_mem_readdatavalid) begin
                    if (restart || r_restart_pending) begin
                        w_addr_nxt    = w_restart_addr;
                        w_pending_nxt = 1'b0;
                        w_state_nxt   = w_restart_state;
                    end else begin
                        w_word_nxt  = flash_mem_readdata;
                        w_dir_nxt   = reverse;
                        w_half_nxt  = reverse;
                        w_state_nxt = READY;
                    end
                end else if (restart) begin
                    w_pending_nxt = 1'b1;
                end else begin
                    w_pending_nxt = r_restart_pending;
                end
                if (w_tick_run) begin
                    w_underrun_nxt = w_underrun_inc;
                end else begin
                    w_underrun_nxt = r_underrun;
                end
            end
            READY: begin
                // restart beats a coincident tick; pause simply ignores ticks
                if (restart) begin
                    w_addr_nxt  = w_restart_addr;
                    w_state_nxt = w_restart_state;
                end else if (w_tick_run) begin
                    w_sample_nxt = select_half(r_word, r_half);
                    w_valid_nxt  = 1'b1;
                    if (r_half == r_dir_q) begin
                        w_half_nxt = ~r_half;
                    end else begin
                        w_addr_nxt  = w_step_addr;
                        w_state_nxt = FETCH;
                    end
                end else begin
                    w_state_nxt = READY;
                end
            end
            default: begin
                w_state_nxt = STOPPED;
            end
        endcase
    end

    // state and output registers
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state           <= STOPPED;
            r_addr            <= BASE;
            r_word            <= {FLASH_DATA_W{1'b0}};
            r_half            <= 1'b0;
            r_dir_q           <= 1'b0;
            r_restart_pending <= 1'b0;
            r_read            <= 1'b0;
            r_sample          <= {SAMPLE_W{1'b0}};
            r_valid           <= 1'b0;
            r_underrun        <= {UNDERRUN_W{1'b0}};
        end else begin
            r_state           <= w_state_nxt;
            r_addr            <= w_addr_nxt;
            r_word            <= w_word_nxt;
            r_half            <= w_half_nxt;
            r_dir_q           <= w_dir_nxt;
            r_restart_pending <= w_pending_nxt;
            r_read            <= (w_state_nxt == FETCH);
            r_sample          <= w_sample_nxt;
            r_valid           <= w_valid_nxt;
            r_underrun        <= w_underrun_nxt;
        end
    end

    assign flash_mem_read       = r_read;
    assign flash_mem_address    = r_addr;
    assign flash_mem_byteenable = 4'hF;
    assign audio_sample         = r_sample;
    assign sample_valid         = r_valid;
    assign underrun_count       = r_underrun;

endmodule

// File: tb/tb_flash_audio_sequencer.sv
// Directed bench for flash_audio_sequencer: hand-computed addresses and samples
// checked with immediate assertions after each clock edge.
module tb_flash_audio_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        play;
    logic        reverse;
    logic        restart;
    logic        sample_tick;
    logic        flash_mem_read;
    logic [22:0] flash_mem_address;
    logic [3:0]  flash_mem_byteenable;
    logic        flash_mem_waitrequest;
    logic [31:0] flash_mem_readdata;
    logic        flash_mem_readdatavalid;
    logic [15:0] audio_sample;
    logic        sample_valid;
    logic [15:0] underrun_count;

    int tests = 0;
    int fails = 0;

    flash_audio_sequencer dut (
        .clk                     (clk),
        .reset                   (reset),
        .play                    (play),
        .reverse                 (reverse),
        .restart                 (restart),
        .sample_tick             (sample_tick),
        .flash_mem_read          (flash_mem_read),
        .flash_mem_address       (flash_mem_address),
        .flash_mem_byteenable    (flash_mem_byteenable),
        .flash_mem_waitrequest   (flash_mem_waitrequest),
        .flash_mem_readdata      (flash_mem_readdata),
        .flash_mem_readdatavalid (flash_mem_readdatavalid),
        .audio_sample            (audio_sample),
        .sample_valid            (sample_valid),
        .underrun_count          (underrun_count)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // wait (bounded) for a read request, check its address, then return the word
    task automatic fetch_word(input string tag, input logic [22:0] exp_addr, input logic [31:0] word);
        for (int i = 0; i < 20 && !flash_mem_read; i++) step();
        chk({tag, "_read"}, {31'd0, flash_mem_read}, 32'd1);
        chk({tag, "_addr"}, {9'd0, flash_mem_address}, {9'd0, exp_addr});
        step();
        flash_mem_readdata      = word;
        flash_mem_readdatavalid = 1'b1;
        step();
        flash_mem_readdatavalid = 1'b0;
        flash_mem_readdata      = 32'h0;
    endtask

    task automatic tick_expect(input string tag, input logic [15:0] exp_sample);
        sample_tick = 1'b1;
        step();
        sample_tick = 1'b0;
        chk({tag, "_valid"}, {31'd0, sample_valid}, 32'd1);
        chk({tag, "_sample"}, {16'd0, audio_sample}, {16'd0, exp_sample});
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1; play = 1'b0; reverse = 1'b0; restart = 1'b0; sample_tick = 1'b0;
        flash_mem_waitrequest = 1'b0; flash_mem_readdata = 32'h0; flash_mem_readdatavalid = 1'b0;

        // reset values
        do_reset();
        chk("rst_read", {31'd0, flash_mem_read}, 32'd0);
        chk("rst_addr", {9'd0, flash_mem_address}, 32'd0);
        chk("rst_sample", {16'd0, audio_sample}, 32'd0);
        chk("rst_valid", {31'd0, sample_valid}, 32'd0);
        chk("rst_underrun", {16'd0, underrun_count}, 32'd0);
        chk("byteenable", {28'd0, flash_mem_byteenable}, 32'hF);

        // forward playback of one word
        play = 1'b1;
        step();
        fetch_word("fwd0", 23'h0, 32'hBBBB_AAAA);
        tick_expect("fwd_lo", 16'hAAAA);
        tick_expect("fwd_hi", 16'hBBBB);
        chk("fwd_next_read", {31'd0, flash_mem_read}, 32'd1);
        chk("fwd_next_addr", {9'd0, flash_mem_address}, 32'd1);
        step();
        chk("valid_pulse_end", {31'd0, sample_valid}, 32'd0);

        // restart while the read at addr 1 is in WAIT_DATA
        restart = 1'b1;
        step();
        restart = 1'b0;
        flash_mem_readdata = 32'hDEAD_BEEF;
        flash_mem_readdatavalid = 1'b1;
        step();
        flash_mem_readdatavalid = 1'b0;
        chk("rs_wd_valid", {31'd0, sample_valid}, 32'd0);
        fetch_word("rs_wd", 23'h0, 32'h1234_5678);
        tick_expect("rs_wd_first", 16'h5678);

        // restart coinciding with a tick in READY
        restart = 1'b1;
        sample_tick = 1'b1;
        step();
        restart = 1'b0;
        sample_tick = 1'b0;
        chk("rs_tick_valid", {31'd0, sample_valid}, 32'd0);
        chk("rs_tick_sample", {16'd0, audio_sample}, 32'h5678);
        chk("rs_tick_read", {31'd0, flash_mem_read}, 32'd1);
        chk("rs_tick_addr", {9'd0, flash_mem_address}, 32'd0);

        // reverse from reset via restart
        do_reset();
        reverse = 1'b1;
        restart = 1'b1;
        step();
        restart = 1'b0;
        fetch_word("rev0", 23'h7FFFF, 32'h2222_1111);
        tick_expect("rev_hi", 16'h2222);
        tick_expect("rev_lo", 16'h1111);
        chk("rev_next_addr", {9'd0, flash_mem_address}, 32'h7FFFE);

        // forward wrap at the top, reverse wrap at the bottom
        do_reset();
        reverse = 1'b1;
        restart = 1'b1;
        step();
        restart = 1'b0;
        reverse = 1'b0;
        fetch_word("wrapf", 23'h7FFFF, 32'h4444_3333);
        tick_expect("wrapf_lo", 16'h3333);
        tick_expect("wrapf_hi", 16'h4444);
        chk("wrapf_addr", {9'd0, flash_mem_address}, 32'h0);
        reverse = 1'b1;
        fetch_word("wrapr", 23'h0, 32'h6666_5555);
        tick_expect("wrapr_hi", 16'h6666);
        tick_expect("wrapr_lo", 16'h5555);
        chk("wrapr_addr", {9'd0, flash_mem_address}, 32'h7FFFF);

        // stalled request with three ticks
        flash_mem_waitrequest = 1'b1;
        for (int i = 0; i < 5; i++) begin
            sample_tick = (i % 2 == 0);
            step();
            sample_tick = 1'b0;
            chk("stall_read", {31'd0, flash_mem_read}, 32'd1);
            chk("stall_addr", {9'd0, flash_mem_address}, 32'h7FFFF);
            chk("stall_valid", {31'd0, sample_valid}, 32'd0);
        end
        chk("underrun3", {16'd0, underrun_count}, 32'd3);
        flash_mem_waitrequest = 1'b0;
        fetch_word("stall", 23'h7FFFF, 32'h8888_7777);
        tick_expect("pause_first", 16'h8888);

        // paused in READY
        play = 1'b0;
        for (int i = 0; i < 4; i++) begin
            sample_tick = 1'b1;
            step();
            sample_tick = 1'b0;
            chk("pause_valid", {31'd0, sample_valid}, 32'd0);
            chk("pause_sample", {16'd0, audio_sample}, 32'h8888);
        end
        chk("pause_underrun", {16'd0, underrun_count}, 32'd3);
        play = 1'b1;
        tick_expect("resume", 16'h7777);
        chk("resume_addr", {9'd0, flash_mem_address}, 32'h7FFFE);

        // underrun saturation
        flash_mem_waitrequest = 1'b1;
        sample_tick = 1'b1;
        repeat (65540) step();
        sample_tick = 1'b0;
        chk("underrun_sat", {16'd0, underrun_count}, 32'hFFFF);
        chk("sat_valid", {31'd0, sample_valid}, 32'd0);

        // reset mid-transaction, then a late readdatavalid in STOPPED
        play = 1'b0;
        do_reset();
        flash_mem_waitrequest = 1'b0;
        flash_mem_readdata = 32'hCAFE_F00D;
        flash_mem_readdatavalid = 1'b1;
        step();
        flash_mem_readdatavalid = 1'b0;
        step();
        chk("late_read", {31'd0, flash_mem_read}, 32'd0);
        chk("late_valid", {31'd0, sample_valid}, 32'd0);
        chk("late_sample", {16'd0, audio_sample}, 32'd0);
        chk("late_underrun", {16'd0, underrun_count}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
